alu_regfile: RTL

//  Operand register file directly upstream of the 8-bit ALU: supplies the A/B operands and

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_regfile_if.sv | 32 +++
 rtl/alu_status_reg.sv | 39 +++
 rtl/alu_regfile.sv | 47 ++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU/regfile defaults, flag bit positions and function-select codes
package alu_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_ADC = 4'd3,
    ALU_SBC = 4'd4,
    ALU_AND = 4'd5,
    ALU_OR  = 4'd6,
    ALU_XOR = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_ROL = 4'd10,
    ALU_ROR = 4'd11,
    ALU_NOT = 4'd12
  } alu_op_e;
endpackage

// File: rtl/alu_regfile_if.sv
// alu_regfile_if: operand read, writeback and status signals between the ALU datapath and its register file
interface alu_regfile_if #(
  parameter int DATA_W = alu_pkg::DEF_DATA_W,
  parameter int ADDR_W = alu_pkg::DEF_ADDR_W
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flag_we;
  logic              c_in;
  logic              n_in;
  logic              v_in;
  logic              z_in;
  logic [3:0]        flags;
  logic              v_sticky;
  logic              clr_sticky;
  modport master (
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
           flag_we, c_in, n_in, v_in, z_in, clr_sticky,
    input  op_a, op_b, flags, v_sticky
  );
  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
           flag_we, c_in, n_in, v_in, z_in, clr_sticky,
    output op_a, op_b, flags, v_sticky
  );
endinterface

// File: rtl/alu_status_reg.sv
// alu_status_reg: {C,N,V,Z} status register plus sticky overflow bit
module alu_status_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we_i,
  input  logic       c_i,
  input  logic       n_i,
  input  logic       v_i,
  input  logic       z_i,
  input  logic       clr_sticky_i,
  output logic [3:0] flags_o,
  output logic       v_sticky_o
);
  logic [3:0] flags_q, flags_d, flags_in;
  logic       sticky_q, sticky_d;
  always_comb begin
    flags_in         = '0;
    flags_in[FLAG_C] = c_i;
    flags_in[FLAG_N] = n_i;
    flags_in[FLAG_V] = v_i;
    flags_in[FLAG_Z] = z_i;
  end
  assign flags_d  = flag_we_i ? flags_in : flags_q;
  // a new overflow outranks a simultaneous clear
  assign sticky_d = (flag_we_i & v_i) | (sticky_q & ~clr_sticky_i);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end
  assign flags_o    = flags_q;
  assign v_sticky_o = sticky_q;
endmodule

// File: rtl/alu_regfile.sv
// alu_regfile: ALU operand register file with registered, write-forwarded reads and status flags
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic         clk,
  input logic         rst,
  alu_regfile_if.slave bus
);
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              wr_ok, fwd_a, fwd_b;
  // R0 is never written, so it reads back zero and is never a forwarding target
  assign wr_ok  = bus.wr_en && bus.wr_addr != '0;
  assign fwd_a  = wr_ok && bus.wr_addr == bus.rd_addr_a;
  assign fwd_b  = wr_ok && bus.wr_addr == bus.rd_addr_b;
  assign op_a_d = bus.rd_en ? (fwd_a ? bus.wr_data : regs_q[bus.rd_addr_a]) : op_a_q;
  assign op_b_d = bus.rd_en ? (fwd_b ? bus.wr_data : regs_q[bus.rd_addr_b]) : op_b_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      if (wr_ok) regs_q[bus.wr_addr] <= bus.wr_data;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
    end
  end
  assign bus.op_a = op_a_q;
  assign bus.op_b = op_b_q;
  alu_status_reg u_status (
    .clk          (clk),
    .rst          (rst),
    .flag_we_i    (bus.flag_we),
    .c_i          (bus.c_in),
    .n_i          (bus.n_in),
    .v_i          (bus.v_in),
    .z_i          (bus.z_in),
    .clr_sticky_i (bus.clr_sticky),
    .flags_o      (bus.flags),
    .v_sticky_o   (bus.v_sticky)
  );
endmodule
